linebuffer_window9: RTL
=======================

# linebuffer_window9

Streaming line buffer that turns a raster pixel stream into a sliding 9x9 window of 7-bit pixels, flattened to 81 elements, for the logistic-regression inner-product stages. It sits directly upstream of the per-class inner-product blocks and drives their `xarray` input together with a one-cycle window-valid strobe. It keeps 8 full image lines plus a 9x9 shift window, and tracks frame position with row and column counters.

## Interface
- `IMG_W`, default 28: pixels per line; must be at least 9.
- `IMG_H`, default 28: lines per frame; must be at least 9.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `pix_valid` input, 1 bit: `pix_in` is accepted this cycle.
- `pix_in` input, 7 bits: unsigned pixel value.
- `sof` input, 1 bit: qualified by `pix_valid`; marks the pixel as (row 0, col 0).
- `xarray` output, unpacked array of 81 elements, `[6:0]` each: flattened window. Index k = 9*r + c, where r is window row (0 = oldest line) and c is window column (0 = oldest pixel). `xarray[80]` is the newest pixel.
- `win_valid` output, 1 bit: one-cycle strobe; `xarray` holds a complete window.
- `frame_done` output, 1 bit: one-cycle strobe after the last pixel of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
- An accepted pixel with `sof`=1 is treated as (0,0) regardless of the counters. Counters then continue from (0,1).
- State machine, one state register:
  - FILL: row < 8. Line buffers load; `win_valid` stays 0.
  - STREAM: row >= 8. Windows are emitted.
  - FILL -> STREAM when the pixel at col IMG_W-1 of row 7 is accepted.
  - STREAM -> FILL on the last pixel of the frame, or on an accepted `sof`.
- Line storage: 8 line memories of IMG_W x 7 bits, addressed by `col`.
  - On each accepted pixel, column `col` is read from all 8 lines.
  - The column shifts up by one line and `pix_in` is written into the newest line.
  - The 9-pixel column (8 stored + `pix_in`) shifts into window column 8; existing window columns shift toward column 0.
- `win_valid` is asserted for an accepted pixel at row >= 8 and col >= 8. No windows straddle a line wrap.
- No backpressure. Downstream must consume each window in the cycle it is strobed.
- Windows per frame: (IMG_W-8) x (IMG_H-8).
- Line memories are never cleared. Stale data from a previous frame is never exposed, because valid windows are gated by the counters.

## Timing
- Latency is 1 cycle. A pixel accepted at edge t produces `xarray` containing it, and `win_valid`=1 when applicable, after edge t.
- `win_valid` and `frame_done` are registered and high for exactly one cycle per qualifying pixel.
  - `frame_done` coincides with the `win_valid` of the last window.
- `xarray` holds its value while `pix_valid`=0.
- Reset values: `xarray` all 0, `win_valid`=0, `frame_done`=0, `row`=0, `col`=0, state FILL. Line memories are unchanged.
- Reset mid-frame: the next accepted pixel is treated as (0,0). No window is emitted until 8 new full lines have been received.
- `sof` together with `reset` in the same cycle: reset wins and the pixel is dropped.
- `sof` arriving mid-frame: the frame is aborted without `frame_done`.
- Gaps in `pix_valid` of any length, including gaps inside a line, do not alter the output sequence.

## Configuration
- `LB_POS_EN` defined:
  - Adds outputs `win_row` [7:0] and `win_col` [7:0]. These hold the frame coordinates of `xarray[80]`, registered alongside `win_valid`, and reset to 0.
- `LB_POS_EN` undefined:
  - These ports and their registers do not exist.
  - All other behaviour is identical.

## Test plan
- Default parameters, one frame with pixel(y,x) = (28y+x) mod 128, continuous `pix_valid`:
  - First `win_valid` follows pixel (8,8), with `xarray[0]`=0, `xarray[8]`=8, `xarray[72]`=96, `xarray[80]`=104.
  - Exactly 400 strobes in the frame, and `frame_done` after pixel (27,27).
- Same frame with random 0–3 cycle gaps on `pix_valid` -> window sequence identical to the gap-free run.
- Two back-to-back frames, the second with all pixels = 127 -> every window of frame 2 is all 127; no strobe occurs before pixel (8,8) of frame 2.
- `reset` asserted at pixel (15,10), then a full frame -> all outputs 0 after the reset edge; 400 correct windows follow.
- `sof` asserted at pixel (12,3) of a frame -> no `frame_done` for the aborted frame; the new frame yields its first window at its own (8,8).
- With `LB_POS_EN`: first strobe has `win_row`=8, `win_col`=8; last strobe has `win_row`=27, `win_col`=27.

Source files
------------

// File: rtl/linebuffer_window9_if.sv
// Pixel stream in, 9x9 window out, for linebuffer_window9.
// LB_POS_EN adds win_row/win_col to the window side.
interface linebuffer_window9_if;
  logic       pix_valid;
  logic [6:0] pix_in;
  logic       sof;
  logic [6:0] xarray [81];
  logic       win_valid;
  logic       frame_done;
`ifdef LB_POS_EN
  logic [7:0] win_row;
  logic [7:0] win_col;
`endif

  modport master (
    output pix_valid,
    output pix_in,
    output sof,
    input  xarray,
    input  win_valid,
`ifdef LB_POS_EN
    input  win_row,
    input  win_col,
`endif
    input  frame_done
  );

  modport slave (
    input  pix_valid,
    input  pix_in,
    input  sof,
    output xarray,
    output win_valid,
`ifdef LB_POS_EN
    output win_row,
    output win_col,
`endif
    output frame_done
  );
endinterface

// File: rtl/linebuffer_window9.sv
// 8-line buffer plus 9x9 sliding window over a raster pixel stream.
// Define LB_POS_EN to add win_row/win_col coordinates of the newest pixel.
module linebuffer_window9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic clk,
  input  logic reset,
  linebuffer_window9_if.slave bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {
    FILL,
    STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] ec;
  logic [RW-1:0] er;
  logic          acc;
  logic          eol;
  logic          eof;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;

  logic [6:0] mem_q [8][IMG_W];
  logic [6:0] colv [9];
  logic [6:0] win_q [81];

`ifdef LB_POS_EN
  logic [7:0] win_row_q;
  logic [7:0] win_col_q;
`endif

  // sof forces the accepted pixel to (0,0)
  always_comb begin
    acc = bus.pix_valid;
    ec  = bus.sof ? '0 : col_q;
    er  = bus.sof ? '0 : row_q;
    eol = (ec == CW'(IMG_W - 1));
    eof = eol && (er == RW'(IMG_H - 1));
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (acc) begin
      col_d = eol ? '0 : ec + 1'b1;
      if (eof) begin
        row_d = '0;
      end else if (eol) begin
        row_d = er + 1'b1;
      end else begin
        row_d = er;
      end
      win_valid_d = (state_q == STREAM) &&
                    !bus.sof &&
                    (ec >= CW'(8));
      frame_done_d = eof;
      unique case (state_q)
        FILL: begin
          if (eol && er == RW'(7)) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          if (eof || bus.sof) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    for (int l = 0; l < 8; l++) begin
      colv[l] = mem_q[l][ec];
    end
    colv[8] = bus.pix_in;
  end

  // line memories have no reset; stale lines are hidden by the counters
  always_ff @(posedge clk) begin
    if (!reset && acc) begin
      for (int l = 0; l < 7; l++) begin
        mem_q[l][ec] <= mem_q[l+1][ec];
      end
      mem_q[7][ec] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 81; k++) begin
        win_q[k] <= '0;
      end
    end else if (acc) begin
      for (int k = 0; k < 81; k++) begin
        if ((k % 9) == 8) begin
          win_q[k] <= colv[k/9];
        end else begin
          win_q[k] <= win_q[k+1];
        end
      end
    end
  end

`ifdef LB_POS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (win_valid_d) begin
      win_row_q <= 8'(er);
      win_col_q <= 8'(ec);
    end
  end

  assign bus.win_row = win_row_q;
  assign bus.win_col = win_col_q;
`endif

  assign bus.xarray     = win_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule
